bcd_down_timer: RTL and testbench

//  Multi-digit BCD down-counting timer: the consuming end of the decade-counter chain.

---
 rtl/bcd_timer_pkg.sv | 20 ++
 rtl/bcd_digit_down.sv | 51 +++++
 rtl/bcd_down_timer.sv | 165 ++++++++++++++++
 tb/tb_bcd_down_timer.sv | 347 ++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/bcd_timer_pkg.sv
// -----------------------------------------------------------------------------
// bcd_timer_pkg
// Shared definitions for the BCD down-counting timer:
//   - FSM state encoding (IDLE / RUN / PAUSED)
//   - BCD_MAX, the largest legal decade digit value
//   - bcd_valid(), a per-digit legality check used when screening presets
// -----------------------------------------------------------------------------
package bcd_timer_pkg;

  localparam logic [1:0] IDLE   = 2'd0;
  localparam logic [1:0] RUN    = 2'd1;
  localparam logic [1:0] PAUSED = 2'd2;

  localparam logic [3:0] BCD_MAX = 4'd9;

  function automatic logic bcd_valid(input logic [3:0] digit);
    return (digit <= BCD_MAX);
  endfunction

endpackage

// File: rtl/bcd_digit_down.sv
// -----------------------------------------------------------------------------
// bcd_digit_down
// One decade digit of the down counter.
// Ports:
//   clk        in   rising-edge clock
//   reset_n    in   asynchronous active-low reset (digit -> 0)
//   load       in   overwrite the digit with load_val (wins over decrement)
//   load_val   in   4-bit value to load
//   dec_en     in   decrement strobe shared by all digits of the chain
//   borrow_in  in   all lower digits are zero (tie high for digit 0)
//   digit      out  current digit value, registered
//   borrow_out out  digit is zero; feeds the borrow chain of the next digit
// -----------------------------------------------------------------------------
module bcd_digit_down
  import bcd_timer_pkg::*;
(
  input  logic       clk,
  input  logic       reset_n,
  input  logic       load,
  input  logic [3:0] load_val,
  input  logic       dec_en,
  input  logic       borrow_in,
  output logic [3:0] digit,
  output logic       borrow_out
);

  logic [3:0] digit_q;
  logic [3:0] digit_d;

  always_comb begin
    digit_d = digit_q;
    if (load) begin
      digit_d = load_val;
    end else if (dec_en && borrow_in) begin
      // A zero digit that is asked to decrement wraps to 9 (it is lending).
      digit_d = (digit_q == 4'd0) ? BCD_MAX : (digit_q - 4'd1);
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      digit_q <= 4'd0;
    end else begin
      digit_q <= digit_d;
    end
  end

  assign digit      = digit_q;
  assign borrow_out = (digit_q == 4'd0);

endmodule

// File: rtl/bcd_down_timer.sv
// -----------------------------------------------------------------------------
// bcd_down_timer
// Multi-digit BCD down-counting timer. A BCD preset is loaded over a
// valid/ready handshake and counted down one step per qualified tick, with the
// borrow rippling from digit to digit. A one-cycle done pulse marks terminal
// count; with auto_reload the preset is reloaded and counting continues.
// Ports:
//   clk          in   rising-edge clock
//   reset_n      in   asynchronous active-low reset
//   load_valid   in   preset offered
//   load_ready   out  preset accepted when load_valid & load_ready (combinational)
//   load_data    in   BCD preset, digit 0 in [3:0]
//   start        in   begin / resume counting
//   stop         in   pause counting
//   clear        in   count <= preset, go IDLE
//   auto_reload  in   reload preset at terminal count instead of halting
//   tick         in   count-enable strobe
//   count        out  current BCD value (registered)
//   busy         out  high while in RUN (registered)
//   done         out  one-cycle terminal-count pulse (registered)
//   load_err     out  one-cycle pulse after a rejected preset (registered)
// -----------------------------------------------------------------------------
module bcd_down_timer
  import bcd_timer_pkg::*;
#(
  parameter int DIGITS = 4
) (
  input  logic                clk,
  input  logic                reset_n,
  input  logic                load_valid,
  output logic                load_ready,
  input  logic [4*DIGITS-1:0] load_data,
  input  logic                start,
  input  logic                stop,
  input  logic                clear,
  input  logic                auto_reload,
  input  logic                tick,
  output logic [4*DIGITS-1:0] count,
  output logic                busy,
  output logic                done,
  output logic                load_err
);

  localparam int W = 4 * DIGITS;

  logic [1:0]        state_q, state_d;
  logic [W-1:0]      preset_q, preset_d;
  logic              busy_q;
  logic              done_q, done_d;
  logic              load_err_q, load_err_d;

  logic [DIGITS-1:0] digit_zero;
  logic [DIGITS-1:0] digit_ok;
  // borrow_chain[i] is high when every digit below i is zero.
  logic [DIGITS:0]   borrow_chain;
  logic [W-1:0]      count_w;

  logic              load_accept;
  logic              load_good;
  logic              terminal;
  logic              tick_run;
  logic              tick_dec;
  logic              tick_term;
  logic              digit_load;
  logic [W-1:0]      digit_load_val;

  assign load_ready  = ((state_q == IDLE) || (state_q == PAUSED)) && !clear;
  assign load_accept = load_valid && load_ready;
  assign load_good   = &digit_ok;

  assign borrow_chain[0] = 1'b1;
  assign terminal        = borrow_chain[DIGITS];

  // A tick only counts in RUN when no higher-priority control is present;
  // this also drops the tick that arrives together with start.
  assign tick_run  = (state_q == RUN) && tick && !clear && !stop && !start;
  assign tick_dec  = tick_run && !terminal;
  assign tick_term = tick_run && terminal;

  genvar gi;
  generate
    for (gi = 0; gi < DIGITS; gi++) begin : g_digit
      assign digit_ok[gi]         = bcd_valid(load_data[4*gi +: 4]);
      assign borrow_chain[gi + 1] = borrow_chain[gi] & digit_zero[gi];

      bcd_digit_down u_digit (
        .clk        (clk),
        .reset_n    (reset_n),
        .load       (digit_load),
        .load_val   (digit_load_val[4*gi +: 4]),
        .dec_en     (tick_dec),
        .borrow_in  (borrow_chain[gi]),
        .digit      (count_w[4*gi +: 4]),
        .borrow_out (digit_zero[gi])
      );
    end
  endgenerate

  always_comb begin
    state_d        = state_q;
    preset_d       = preset_q;
    done_d         = 1'b0;
    load_err_d     = 1'b0;
    digit_load     = 1'b0;
    digit_load_val = preset_q;

    // Loads are only accepted in IDLE/PAUSED, reloads only happen in RUN and
    // clear blocks acceptance, so at most one source drives the digit load.
    if (load_accept) begin
      if (load_good) begin
        preset_d       = load_data;
        digit_load     = 1'b1;
        digit_load_val = load_data;
      end else begin
        load_err_d = 1'b1;
      end
    end

    if (state_q != IDLE && state_q != RUN && state_q != PAUSED) begin
      state_d = IDLE;
    end

    if (clear) begin
      state_d        = IDLE;
      digit_load     = 1'b1;
      digit_load_val = preset_q;
    end else if (stop) begin
      if (state_q == RUN) begin
        state_d = PAUSED;
      end
    end else if (start) begin
      state_d = RUN;
    end else if (tick_term) begin
      done_d = 1'b1;
      if (auto_reload) begin
        digit_load     = 1'b1;
        digit_load_val = preset_q;
      end else begin
        state_d = IDLE;
      end
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q    <= IDLE;
      preset_q   <= '0;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
      load_err_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      preset_q   <= preset_d;
      busy_q     <= (state_d == RUN);
      done_q     <= done_d;
      load_err_q <= load_err_d;
    end
  end

  assign count    = count_w;
  assign busy     = busy_q;
  assign done     = done_q;
  assign load_err = load_err_q;

endmodule

// File: tb/tb_bcd_down_timer.sv
// -----------------------------------------------------------------------------
// tb_bcd_down_timer
// Self-checking bench for bcd_down_timer. A reference model keeps the count as
// a plain integer and the mode as a small enumeration; BCD conversion happens
// only at the comparison point.
// -----------------------------------------------------------------------------
module tb_bcd_down_timer;

  localparam int DIGITS = 4;
  localparam int W      = 4 * DIGITS;

  localparam int M_IDLE   = 0;
  localparam int M_RUN    = 1;
  localparam int M_PAUSED = 2;

  logic         clk         = 1'b0;
  logic         reset_n     = 1'b0;
  logic         load_valid  = 1'b0;
  logic [W-1:0] load_data   = '0;
  logic         start       = 1'b0;
  logic         stop        = 1'b0;
  logic         clear       = 1'b0;
  logic         auto_reload = 1'b0;
  logic         tick        = 1'b0;
  logic         load_ready;
  logic [W-1:0] count;
  logic         busy;
  logic         done;
  logic         load_err;

  int checks   = 0;
  int failures = 0;

  int m_state;
  int m_preset;
  int m_count;
  bit m_done;
  bit m_err;

  always #5 clk = ~clk;

  bcd_down_timer #(.DIGITS(DIGITS)) dut (
    .clk         (clk),
    .reset_n     (reset_n),
    .load_valid  (load_valid),
    .load_ready  (load_ready),
    .load_data   (load_data),
    .start       (start),
    .stop        (stop),
    .clear       (clear),
    .auto_reload (auto_reload),
    .tick        (tick),
    .count       (count),
    .busy        (busy),
    .done        (done),
    .load_err    (load_err)
  );

  // ---------------- reference model ----------------
  function automatic logic [W-1:0] to_bcd(input int v);
    logic [W-1:0] r;
    int x;
    r = '0;
    x = v;
    for (int i = 0; i < DIGITS; i++) begin
      r[4*i +: 4] = 4'(x % 10);
      x = x / 10;
    end
    return r;
  endfunction

  function automatic bit is_bcd(input logic [W-1:0] d);
    for (int i = 0; i < DIGITS; i++) begin
      if (d[4*i +: 4] > 4'd9) return 1'b0;
    end
    return 1'b1;
  endfunction

  function automatic int from_bcd(input logic [W-1:0] d);
    int v;
    v = 0;
    for (int i = DIGITS - 1; i >= 0; i--) v = v * 10 + int'(d[4*i +: 4]);
    return v;
  endfunction

  function automatic bit m_ready();
    return (m_state != M_RUN) && !clear;
  endfunction

  task automatic model_reset();
    m_state  = M_IDLE;
    m_preset = 0;
    m_count  = 0;
    m_done   = 1'b0;
    m_err    = 1'b0;
  endtask

  // Advance the model by one clock using the inputs currently applied.
  task automatic model_update();
    bit rdy;
    rdy    = m_ready();
    m_done = 1'b0;
    m_err  = 1'b0;
    if (load_valid && rdy) begin
      if (is_bcd(load_data)) begin
        m_preset = from_bcd(load_data);
        m_count  = m_preset;
      end else begin
        m_err = 1'b1;
      end
    end
    if (clear) begin
      m_count = m_preset;
      m_state = M_IDLE;
    end else if (stop) begin
      if (m_state == M_RUN) m_state = M_PAUSED;
    end else if (start) begin
      m_state = M_RUN;
    end else if (tick && m_state == M_RUN) begin
      if (m_count == 0) begin
        m_done = 1'b1;
        if (auto_reload) m_count = m_preset;
        else m_state = M_IDLE;
      end else begin
        m_count = m_count - 1;
      end
    end
  endtask

  // ---------------- stimulus helpers (no checking) ----------------
  task automatic drive(input logic lv, input logic [W-1:0] ld, input logic st,
                       input logic sp, input logic cl, input logic tk);
    load_valid = lv;
    load_data  = ld;
    start      = st;
    stop       = sp;
    clear      = cl;
    tick       = tk;
  endtask

  task automatic idle_in();
    drive(1'b0, '0, 1'b0, 1'b0, 1'b0, 1'b0);
  endtask

  task automatic step();
    model_update();
    @(posedge clk);
    #1;
  endtask

  task automatic do_load(input logic [W-1:0] ld);
    drive(1'b1, ld, 1'b0, 1'b0, 1'b0, 1'b0);
    step();
    idle_in();
  endtask

  task automatic do_start();
    drive(1'b0, '0, 1'b1, 1'b0, 1'b0, 1'b0);
    step();
    idle_in();
  endtask

  task automatic do_tick();
    drive(1'b0, '0, 1'b0, 1'b0, 1'b0, 1'b1);
    step();
    idle_in();
  endtask

  task automatic do_clear();
    drive(1'b0, '0, 1'b0, 1'b0, 1'b1, 1'b0);
    step();
    idle_in();
  endtask

  // ---------------- tests ----------------
  task automatic test_reset();
    reset_n = 1'b0;
    idle_in();
    repeat (2) @(posedge clk);
    #1;
    model_reset();
    checks++; if (count !== 16'h0000) begin failures++; $display("FAIL reset_count got=%h exp=0000", count); end
    checks++; if (busy !== 1'b0) begin failures++; $display("FAIL reset_busy got=%b exp=0", busy); end
    checks++; if (done !== 1'b0) begin failures++; $display("FAIL reset_done got=%b exp=0", done); end
    checks++; if (load_err !== 1'b0) begin failures++; $display("FAIL reset_load_err got=%b exp=0", load_err); end
    checks++; if (load_ready !== 1'b1) begin failures++; $display("FAIL reset_ready got=%b exp=1", load_ready); end
    reset_n = 1'b1;
    $display("test_reset done");
  endtask

  task automatic test_countdown();
    logic [W-1:0] exp_c;
    auto_reload = 1'b0;
    do_load(16'h0012);
    checks++; if (count !== 16'h0012) begin failures++; $display("FAIL cd_load got=%h exp=0012", count); end
    do_start();
    checks++; if (busy !== 1'b1) begin failures++; $display("FAIL cd_busy got=%b exp=1", busy); end
    for (int k = 1; k <= 13; k++) begin
      do_tick();
      exp_c = (k <= 12) ? to_bcd(12 - k) : 16'h0000;
      checks++; if (count !== exp_c) begin failures++; $display("FAIL cd_count tick=%0d got=%h exp=%h", k, count, exp_c); end
      checks++; if (done !== (k == 13)) begin failures++; $display("FAIL cd_done tick=%0d got=%b exp=%b", k, done, (k == 13)); end
      $display("countdown tick=%0d count=%h done=%b", k, count, done);
    end
    checks++; if (busy !== 1'b0) begin failures++; $display("FAIL cd_idle_busy got=%b exp=0", busy); end
    do_tick();
    checks++; if (done !== 1'b0) begin failures++; $display("FAIL cd_done_once got=%b exp=0", done); end
    checks++; if (count !== 16'h0000) begin failures++; $display("FAIL cd_hold got=%h exp=0000", count); end
  endtask

  task automatic test_borrow();
    do_load(16'h1000);
    do_start();
    do_tick();
    checks++; if (count !== 16'h0999) begin failures++; $display("FAIL borrow_count got=%h exp=0999", count); end
    checks++; if (done !== 1'b0) begin failures++; $display("FAIL borrow_done got=%b exp=0", done); end
    checks++; if (busy !== 1'b1) begin failures++; $display("FAIL borrow_busy got=%b exp=1", busy); end
    do_clear();
    checks++; if (count !== 16'h1000) begin failures++; $display("FAIL borrow_clear got=%h exp=1000", count); end
    checks++; if (busy !== 1'b0) begin failures++; $display("FAIL borrow_clear_busy got=%b exp=0", busy); end
    $display("borrow count=%h", count);
  endtask

  task automatic test_auto_reload();
    logic [W-1:0] exp_c;
    do_load(16'h0002);
    auto_reload = 1'b1;
    do_start();
    for (int k = 1; k <= 9; k++) begin
      do_tick();
      exp_c = (k % 3 == 0) ? 16'h0002 : to_bcd(2 - (k % 3));
      checks++; if (count !== exp_c) begin failures++; $display("FAIL ar_count tick=%0d got=%h exp=%h", k, count, exp_c); end
      checks++; if (done !== (k % 3 == 0)) begin failures++; $display("FAIL ar_done tick=%0d got=%b exp=%b", k, done, (k % 3 == 0)); end
      checks++; if (busy !== 1'b1) begin failures++; $display("FAIL ar_busy tick=%0d got=%b exp=1", k, busy); end
      $display("auto_reload tick=%0d count=%h done=%b", k, count, done);
    end
    do_clear();
    auto_reload = 1'b0;
    checks++; if (busy !== 1'b0) begin failures++; $display("FAIL ar_clear_busy got=%b exp=0", busy); end
  endtask

  task automatic test_load_err();
    do_load(16'h0042);
    checks++; if (load_err !== 1'b0) begin failures++; $display("FAIL le_good got=%b exp=0", load_err); end
    do_load(16'h00A5);
    checks++; if (load_err !== 1'b1) begin failures++; $display("FAIL le_pulse got=%b exp=1", load_err); end
    checks++; if (count !== 16'h0042) begin failures++; $display("FAIL le_count got=%h exp=0042", count); end
    checks++; if (busy !== 1'b0) begin failures++; $display("FAIL le_state got=%b exp=0", busy); end
    step();
    checks++; if (load_err !== 1'b0) begin failures++; $display("FAIL le_one_cycle got=%b exp=0", load_err); end
    do_start();
    checks++; if (load_ready !== 1'b0) begin failures++; $display("FAIL le_ready_run got=%b exp=0", load_ready); end
    do_load(16'h0777);
    checks++; if (count !== 16'h0042) begin failures++; $display("FAIL le_run_load got=%h exp=0042", count); end
    do_tick();
    checks++; if (count !== 16'h0041) begin failures++; $display("FAIL le_tick got=%h exp=0041", count); end
    do_clear();
    checks++; if (count !== 16'h0042) begin failures++; $display("FAIL le_preset got=%h exp=0042", count); end
    $display("load_err preset kept count=%h", count);
  endtask

  task automatic test_stop_start();
    do_load(16'h0050);
    do_start();
    drive(1'b0, '0, 1'b1, 1'b1, 1'b0, 1'b0);
    step();
    idle_in();
    checks++; if (busy !== 1'b0) begin failures++; $display("FAIL ss_paused got=%b exp=0", busy); end
    checks++; if (load_ready !== 1'b1) begin failures++; $display("FAIL ss_ready got=%b exp=1", load_ready); end
    repeat (3) do_tick();
    checks++; if (count !== 16'h0050) begin failures++; $display("FAIL ss_hold got=%h exp=0050", count); end
    do_start();
    checks++; if (busy !== 1'b1) begin failures++; $display("FAIL ss_resume got=%b exp=1", busy); end
    do_tick();
    checks++; if (count !== 16'h0049) begin failures++; $display("FAIL ss_tick got=%h exp=0049", count); end
    do_clear();
    $display("stop_start resumed count ok");
  endtask

  task automatic test_reset_midrun();
    do_load(16'h0007);
    do_start();
    do_tick();
    checks++; if (count !== 16'h0006) begin failures++; $display("FAIL rm_pre got=%h exp=0006", count); end
    #2;
    reset_n = 1'b0;
    #1;
    model_reset();
    checks++; if (count !== 16'h0000) begin failures++; $display("FAIL rm_count got=%h exp=0000", count); end
    checks++; if (busy !== 1'b0) begin failures++; $display("FAIL rm_busy got=%b exp=0", busy); end
    checks++; if (done !== 1'b0) begin failures++; $display("FAIL rm_done got=%b exp=0", done); end
    @(posedge clk);
    #1;
    reset_n = 1'b1;
    do_clear();
    checks++; if (count !== 16'h0000) begin failures++; $display("FAIL rm_preset_lost got=%h exp=0000", count); end
    do_load(16'h0007);
    do_start();
    do_tick();
    do_tick();
    checks++; if (count !== 16'h0005) begin failures++; $display("FAIL rm_run got=%h exp=0005", count); end
    do_clear();
    checks++; if (count !== 16'h0007) begin failures++; $display("FAIL rm_clear got=%h exp=0007", count); end
    checks++; if (busy !== 1'b0) begin failures++; $display("FAIL rm_clear_busy got=%b exp=0", busy); end
    $display("reset_midrun count=%h", count);
  endtask

  task automatic test_random();
    logic         lv, st, sp, cl, tk;
    logic [W-1:0] ld;
    for (int n = 0; n < 400; n++) begin
      lv = ($urandom % 4 == 0);
      ld = ($urandom % 4 == 0) ? W'($urandom) : to_bcd(int'($urandom_range(0, 30)));
      st = ($urandom % 6 == 0);
      sp = ($urandom % 12 == 0);
      cl = ($urandom % 30 == 0);
      tk = ($urandom % 3 != 0);
      if ($urandom % 20 == 0) auto_reload = ~auto_reload;
      drive(lv, ld, st, sp, cl, tk);
      #1;
      checks++; if (load_ready !== m_ready()) begin failures++; $display("FAIL rnd_ready n=%0d got=%b exp=%b", n, load_ready, m_ready()); end
      step();
      checks++; if (count !== to_bcd(m_count)) begin failures++; $display("FAIL rnd_count n=%0d got=%h exp=%h", n, count, to_bcd(m_count)); end
      checks++; if (busy !== (m_state == M_RUN)) begin failures++; $display("FAIL rnd_busy n=%0d got=%b exp=%b", n, busy, (m_state == M_RUN)); end
      checks++; if (done !== m_done) begin failures++; $display("FAIL rnd_done n=%0d got=%b exp=%b", n, done, m_done); end
      checks++; if (load_err !== m_err) begin failures++; $display("FAIL rnd_load_err n=%0d got=%b exp=%b", n, load_err, m_err); end
      if (n % 40 == 0) $display("random n=%0d count=%h busy=%b done=%b", n, count, busy, done);
    end
    idle_in();
    auto_reload = 1'b0;
  endtask

  initial begin
    model_reset();
    test_reset();
    test_countdown();
    test_borrow();
    test_auto_reload();
    test_load_err();
    test_stop_start();
    test_reset_midrun();
    test_random();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
